// File: rtl/fixed_point_expander.sv
// fixed_point_expander: widens signed Q8.8 words to signed Q16.16 and passes
// them through a 2-entry elastic buffer with valid/ready on both sides.
// A frame counter marks the last word of each kernel window (out_last) and
// pulses frame_done the cycle after that word leaves the buffer.
module fixed_point_expander #(
    parameter int DATA_BITS     = 16,
    parameter int INTERNAL_BITS = 32,
    parameter int FRAC_SHIFT    = 8,
    parameter int FRAME_LEN     = 9,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_BITS-1:0]     in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [INTERNAL_BITS-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     frame_done
);

    localparam int SIGN_BITS = INTERNAL_BITS - DATA_BITS - FRAC_SHIFT;
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [1:0]       DEPTH_W  = 2'(DEPTH);

    logic [1:0]               count, count_nxt;
    logic [INTERNAL_BITS-1:0] head, head_nxt;
    logic [INTERNAL_BITS-1:0] tail, tail_nxt;
    logic [CNT_W-1:0]         frame_cnt, frame_nxt;
    logic                     frame_done_nxt;
    logic [INTERNAL_BITS-1:0] conv;
    logic                     push, pop;

    // Pure bit placement: sign-extend above, zero fraction bits below.
    assign conv = {{SIGN_BITS{in_data[DATA_BITS-1]}}, in_data, {FRAC_SHIFT{1'b0}}};

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = head;
    assign out_last = out_valid && (frame_cnt == LAST_IDX);

    // Next-state for buffer occupancy, entries and frame position.
    always_comb begin
        count_nxt      = count;
        head_nxt       = head;
        tail_nxt       = tail;
        frame_nxt      = frame_cnt;
        frame_done_nxt = 1'b0;
        if (clear) begin
            count_nxt = '0;
            frame_nxt = '0;
        end else begin
            if (pop) begin
                frame_nxt      = (frame_cnt == LAST_IDX) ? '0 : frame_cnt + CNT_W'(1);
                frame_done_nxt = out_last;
            end
            // push implies count < 2 and pop implies count > 0, so push+pop
            // only occurs with one entry held: the new word replaces the head.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_nxt  = conv;
                        count_nxt = 2'd1;
                    end else begin
                        tail_nxt  = conv;
                        count_nxt = 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_nxt = tail;
                    end
                    count_nxt = count - 2'd1;
                end
                2'b11: begin
                    head_nxt = conv;
                end
                default: ;
            endcase
        end
    end

    // State registers; handshake outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            frame_cnt  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            count      <= count_nxt;
            head       <= head_nxt;
            tail       <= tail_nxt;
            frame_cnt  <= frame_nxt;
            in_ready   <= (count_nxt < DEPTH_W);
            out_valid  <= (count_nxt != 2'd0);
            frame_done <= frame_done_nxt;
        end
    end

endmodule
